// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier.
// Operands load in parallel on a valid/ready handshake. Signed or unsigned
// mode is chosen per transaction by in_signed. The product is held while
// out_ready is low.
module booth_mult_seq #(
   parameter int WIDTH = 8,
   // Derived from WIDTH; leave at its default.
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // A, Q and M carry one extra bit. An unsigned operand is zero-extended
   // into that bit, so the signed Booth core also handles unsigned inputs.
   logic [WIDTH:0]   a_reg;
   logic [WIDTH:0]   q_reg;
   logic [WIDTH:0]   m_reg;
   logic             q_1;
   logic [CNT_W-1:0] cnt;

   logic             sxa;
   logic             sxb;
   logic             accept;
   logic             last_iter;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   q_sh;

   assign sxa       = in_signed & in_a[WIDTH-1];
   assign sxb       = in_signed & in_b[WIDTH-1];
   assign accept    = in_valid && (state == IDLE);
   assign last_iter = (cnt == CNT_W'(1));

   // Booth add/subtract selected by {Q[0], q_1}, followed by an
   // arithmetic right shift of {A, Q, q_1}.
   always_comb begin
      sum = a_reg;
      unique case ({q_reg[0], q_1})
         2'b01:   sum = a_reg + m_reg;
         2'b10:   sum = a_reg - m_reg;
         default: sum = a_reg;
      endcase
      a_sh = {sum[WIDTH], sum[WIDTH:1]};
      q_sh = {sum[0], q_reg[WIDTH:1]};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_iter) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from the state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: load on accept, iterate in RUN, register product on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         q_reg   <= '0;
         m_reg   <= '0;
         q_1     <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         m_reg <= {sxa, in_a};
         q_reg <= {sxb, in_b};
         a_reg <= '0;
         q_1   <= 1'b0;
         cnt   <= CNT_W'(WIDTH + 1);
      end else if (state == RUN) begin
         a_reg <= a_sh;
         q_reg <= q_sh;
         q_1   <= q_reg[0];
         cnt   <= cnt - CNT_W'(1);
         // The low 2*WIDTH bits of the shifted {A, Q} are the product.
         // The two discarded top bits only carry extension.
         if (last_iter) begin
            product <= {a_sh[WIDTH-2:0], q_sh};
         end
      end
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's DATAPATH+controller Booth multiplier.
- Both operands load in parallel on a valid/ready input handshake; the old serial shared data bus is gone.
- Width is a parameter.
- Signed or unsigned mode is selected per transaction.
- The result is held under output back-pressure.
- It sits between an operand producer and a result consumer in arithmetic test designs.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b, signed or unsigned per captured in_signed
busy  output  1  high in RUN or DONE

Behaviour:
Reset:
- rst_n low clears asynchronously: state=IDLE, internal A, Q, M, q_1, cnt, product all 0; out_valid=0, busy=0.
- in_ready = (state==IDLE), so it reads 1 during reset; no capture occurs while rst_n is low.

Internal datapath:
- A, Q and M are WIDTH+1 bits; q_1 is 1 bit.
- Extension bit sx = in_signed ? operand MSB : 0. This extension makes one Booth core serve both modes.

State machine:
- IDLE → RUN on (in_valid && in_ready) at edge E0. At E0: M={sxa,in_a}, Q={sxb,in_b}, A=0, q_1=0, cnt=WIDTH+1.
- RUN, each cycle, on {Q[0],q_1}:
  - 01 → A=A+M; 10 → A=A−M; 00/11 → no add.
  - Both arithmetic is modulo 2^(WIDTH+1).
  - Then arithmetic right shift of {A,Q,q_1} by one; the MSB of A is replicated.
  - cnt decrements.
  - On the cycle in which cnt goes 1→0, transition to DONE and register product = {A,Q}[2*WIDTH-1:0] of the shifted value.
- DONE: out_valid=1; product is stable. On out_ready=1 at an edge → IDLE, out_valid=0. product keeps its last value until the next completion.

Timing and flow:
- Latency: out_valid is first high after edge E0+WIDTH+1, i.e. WIDTH+1 clocks after acceptance.
- Throughput: one product per WIDTH+3 cycles minimum. The block never accepts in the DONE→IDLE cycle; in_ready rises only after returning to IDLE.
- in_valid, in_a, in_b and in_signed are ignored outside IDLE. Operands changing mid-RUN have no effect.
- out_ready is ignored outside DONE.
- out_valid held with out_ready=0 keeps product and out_valid stable indefinitely.

Reset mid-operation:
- rst_n low in RUN or DONE aborts immediately; all outputs return to reset values.
- After release, the first accepted operands are computed normally; no state leaks from the aborted operation.

Boundary conditions:
- Most-negative × most-negative (signed) is exact in 2*WIDTH bits.
- All-ones × all-ones (unsigned) is exact.
- Any operand 0 gives product 0 with the full latency; there is no early termination.

Test Plan:
- WIDTH=8, unsigned 5×8 accepted at edge E0 → out_valid high after E0+9, product=0x0028; busy high E0+1..completion.
- Signed −5 (0xFB) × 8 → 0xFFD8. Signed −128×−128 (0x80,0x80) → 0x4000. Signed 127×−128 → 0xC080.
- Unsigned 255×255 → 0xFE01. Same bit patterns signed (−1×−1) → 0x0001.
- Back-pressure: hold out_ready=0 for 20 cycles after completion → out_valid and product stable, in_ready=0. Then out_ready=1 → IDLE next edge, and in_ready=1 in the following cycle.
- Change in_a/in_b and pulse in_valid during RUN → result unaffected, no second capture. rst_n pulse low mid-RUN → out_valid=0, busy=0, in_ready=1 immediately; next transaction 3×(−7) signed → 0xFFEB.
- Random regression, WIDTH in {2,8,16}, 1000 vectors, random in_signed, random out_ready stalls → matches reference model.
